// File: rtl/img_stream_pkg.sv
// -----------------------------------------------------------------------------
// img_stream_pkg
// Shared definitions for the grey-image stream protocol (vsync frames a frame,
// href qualifies each active row, one 8-bit grey pixel per href cycle).
// Used by the frame source and by the sink/checker blocks.
//   state_t        : controller states of the frame source
//   DEF_*          : default geometry and blanking constants
//   cnt_w / max2   : counter-width helpers usable in parameter expressions
// -----------------------------------------------------------------------------
package img_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_LEAD,
    ST_ACTIVE,
    ST_HBLK,
    ST_TAIL
  } state_t;

  localparam int DEF_IMG_H_DISP = 640;
  localparam int DEF_IMG_V_DISP = 480;
  localparam int DEF_H_BLANK    = 10;
  localparam int DEF_V_LEAD     = 5;
  localparam int DEF_V_TAIL     = 1;
  localparam int DEF_FRAME_GAP  = 5;
  localparam int DEF_ADDR_W     = 19;
  localparam int PIX_W          = 8;

  // Bits needed to count 0..n-1; never less than one bit so n=1 still works.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/img_sync_delay.sv
// -----------------------------------------------------------------------------
// img_sync_delay
// N-stage register chain used to align the controller's vsync/href with the
// memory read latency and the output data register.
//   clk, rst_n : clock, synchronous active-low reset (clears every stage)
//   i_d        : input word (W bits)
//   o_first    : output of the first stage (1 cycle delay)
//   o_q        : output of the last stage (N cycles delay)
// -----------------------------------------------------------------------------
module img_sync_delay #(
  parameter int N = 2,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_first,
  output logic [W-1:0] o_q
);

  logic [N-1:0][W-1:0] r_stage;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < N; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_first = r_stage[0];
  assign o_q     = r_stage[N-1];

endmodule

// File: rtl/img_stream_gen.sv
// -----------------------------------------------------------------------------
// img_stream_gen
// Frame source for the grey-image stream protocol. Reads pixels from a
// synchronous-read frame memory (1-cycle latency) and emits them with
// programmable row (H_BLANK) and frame (FRAME_GAP/V_LEAD/V_TAIL) blanking.
//   clk, rst_n     : clock, synchronous active-low reset
//   i_start        : one-cycle pulse, starts a frame when idle
//   i_continuous   : sampled at frame end, 1 = start the next frame at once
//   o_busy         : controller not idle
//   o_frame_done   : one-cycle pulse, first cycle with o_vsync low after a frame
//   o_rd_en        : memory read strobe
//   o_rd_addr      : linear pixel address row*IMG_H_DISP+col
//   i_rd_data      : memory data, valid the cycle after o_rd_en
//   o_vsync        : frame valid
//   o_href         : pixel valid
//   o_gray         : pixel value, zero whenever o_href is low
// Latency: o_rd_en at cycle t -> o_href/o_gray for that address at t+2.
// -----------------------------------------------------------------------------
module img_stream_gen
  import img_stream_pkg::*;
#(
  parameter int IMG_H_DISP = DEF_IMG_H_DISP,
  parameter int IMG_V_DISP = DEF_IMG_V_DISP,
  parameter int H_BLANK    = DEF_H_BLANK,
  parameter int V_LEAD     = DEF_V_LEAD,
  parameter int V_TAIL     = DEF_V_TAIL,
  parameter int FRAME_GAP  = DEF_FRAME_GAP,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_continuous,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [PIX_W-1:0]  i_rd_data,
  output logic              o_vsync,
  output logic              o_href,
  output logic [PIX_W-1:0]  o_gray
);

  localparam int COL_W  = cnt_w(IMG_H_DISP);
  localparam int ROW_W  = cnt_w(IMG_V_DISP);
  localparam int PH_MAX = max2(max2(FRAME_GAP, V_LEAD), max2(H_BLANK, V_TAIL));
  localparam int PH_W   = cnt_w(PH_MAX);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_H_DISP - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_V_DISP - 1);
  localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(FRAME_GAP - 1);
  localparam logic [PH_W-1:0]  LEAD_LAST = PH_W'(V_LEAD - 1);
  localparam logic [PH_W-1:0]  HBLK_LAST = PH_W'(H_BLANK - 1);
  localparam logic [PH_W-1:0]  TAIL_LAST = PH_W'(V_TAIL - 1);

  state_t              r_state;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [PH_W-1:0]     r_phase;
  logic                r_busy;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_vs_c;
  logic                r_hr_c;

  logic [1:0]          w_sync_p1;
  logic [1:0]          w_sync_p2;
  logic                w_hr_p1;
  logic                w_vs_p1;
  logic [PIX_W-1:0]    r_gray_p2;
  logic                r_frame_done;

  // ---- Control stage (p0): FSM, counters, read strobe/address, vs_c/hr_c ----
  // Outputs are assigned together with the next state so every control output
  // is a plain register that already matches the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_phase   <= '0;
      r_busy    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_vs_c    <= 1'b0;
      r_hr_c    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= ST_GAP;
            r_col     <= '0;
            r_row     <= '0;
            r_phase   <= '0;
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
          end
        end

        ST_GAP: begin
          if (r_phase == GAP_LAST) begin
            r_phase <= '0;
            r_state <= ST_LEAD;
            r_vs_c  <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        ST_LEAD: begin
          if (r_phase == LEAD_LAST) begin
            r_phase <= '0;
            r_state <= ST_ACTIVE;
            r_rd_en <= 1'b1;
            r_hr_c  <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (r_col == COL_LAST) begin
            r_col   <= '0;
            r_rd_en <= 1'b0;
            r_hr_c  <= 1'b0;
            if (r_row == ROW_LAST) begin
              // Last pixel of the frame: address wraps so the next frame
              // starts from 0 and never runs past the frame buffer.
              r_row     <= '0;
              r_rd_addr <= '0;
              r_state   <= ST_TAIL;
            end else begin
              // Address steps to the next row start and holds through HBLK.
              r_row     <= r_row + 1'b1;
              r_rd_addr <= r_rd_addr + 1'b1;
              r_state   <= ST_HBLK;
            end
          end else begin
            r_col     <= r_col + 1'b1;
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end

        ST_HBLK: begin
          if (r_phase == HBLK_LAST) begin
            r_phase <= '0;
            r_state <= ST_ACTIVE;
            r_rd_en <= 1'b1;
            r_hr_c  <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        ST_TAIL: begin
          if (r_phase == TAIL_LAST) begin
            r_phase <= '0;
            r_vs_c  <= 1'b0;
            if (i_continuous) begin
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_rd_en <= 1'b0;
          r_vs_c  <= 1'b0;
          r_hr_c  <= 1'b0;
        end
      endcase
    end
  end

  // ---- Sync alignment (p1, p2): vs/hr follow the memory latency ----
  img_sync_delay #(
    .N (2),
    .W (2)
  ) u_sync_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     ({r_vs_c, r_hr_c}),
    .o_first (w_sync_p1),
    .o_q     (w_sync_p2)
  );

  assign w_vs_p1 = w_sync_p1[1];
  assign w_hr_p1 = w_sync_p1[0];

  // ---- Output stage (p2): gated pixel register and frame_done ----
  // rd_data is valid exactly while the p1 copy of href is high, so that bit
  // gates the data register and keeps o_gray at zero outside href.
  // frame_done fires when p2 vsync is still high but p1 has already dropped,
  // landing the pulse on the first cycle o_vsync is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gray_p2    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_gray_p2    <= w_hr_p1 ? i_rd_data : '0;
      r_frame_done <= w_sync_p2[1] & ~w_vs_p1;
    end
  end

  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_rd_en      = r_rd_en;
  assign o_rd_addr    = r_rd_addr;
  assign o_vsync      = w_sync_p2[1];
  assign o_href       = w_sync_p2[0];
  assign o_gray       = r_gray_p2;

endmodule

// File: doc/img_stream_gen.md
# img_stream_gen

Synthesizable frame-source (transmitter) for the team's grey-image stream protocol: vsync framing a frame, href qualifying each active row, 8-bit grey pixel per href cycle. It fetches pixels from a synchronous-read frame memory (1-cycle read latency) and emits them with programmable row and frame blanking. It sits upstream of filter blocks such as the bilateral filter, on-chip and in benches, in place of behavioural stimulus.

## Interface
- IMG_H_DISP, 640, active pixels per row (>=1)
- IMG_V_DISP, 480, active rows per frame (>=1)
- H_BLANK, 10, href-low cycles between rows, vsync held high (>=1)
- V_LEAD, 5, vsync-high cycles before first href of a frame (>=1)
- V_TAIL, 1, vsync-high cycles after last href of a frame (>=1)
- FRAME_GAP, 5, vsync-low cycles before vsync rises (>=1)
- ADDR_W, 19, memory address width (>= clog2(IMG_H_DISP*IMG_V_DISP))
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a frame when idle
- continuous  in  1  sampled at end of frame; 1 = start next frame immediately
- busy  out  1  high from accepted start until frame end (controller not IDLE)
- frame_done  out  1  one-cycle pulse, cycle after out_vsync falls
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  linear pixel address, row*IMG_H_DISP+col
- rd_data  in  8  memory data, valid cycle after rd_en
- out_vsync  out  1  frame valid
- out_href  out  1  pixel valid
- out_gray  out  8  pixel value

## Operation
- Controller FSM states: IDLE, GAP, LEAD, ACTIVE, HBLK, TAIL.
- IDLE: wait for start. start -> GAP, counters cleared, busy=1.
- GAP: FRAME_GAP cycles, vsync low -> LEAD.
- LEAD: V_LEAD cycles, vsync high, href low -> ACTIVE.
- ACTIVE: IMG_H_DISP cycles, rd_en=1, rd_addr increments by 1 each cycle. Last column: last row -> TAIL, else -> HBLK (row+1).
- HBLK: H_BLANK cycles, vsync high, href low -> ACTIVE.
- TAIL: V_TAIL cycles, vsync high -> GAP if continuous=1, else IDLE.
- rd_addr wraps to 0 at frame end; never exceeds IMG_H_DISP*IMG_V_DISP-1. rd_addr holds value when rd_en=0.
- start while busy: ignored. continuous dropped mid-frame: current frame completes, then IDLE.
- Frame period (cycles) = FRAME_GAP + V_LEAD + V*H + (V-1)*H_BLANK + V_TAIL.

## Timing
- Control-stage vsync/href (vs_c/hr_c) are delayed two registers to out_vsync/out_href; out_gray registers rd_data. Net: rd_en at cycle t -> out_href=1 and out_gray=mem[rd_addr(t)] at t+2.
- out_gray = 0 whenever out_href = 0.
- out_vsync rises exactly V_LEAD cycles before first out_href; falls exactly V_TAIL cycles after last out_href.
- frame_done asserted the cycle after out_vsync 1->0 edge; busy falls with the controller leaving TAIL (i.e. ~2 cycles before frame_done in non-continuous mode).
- Reset values (all outputs): busy 0, frame_done 0, rd_en 0, rd_addr 0, out_vsync 0, out_href 0, out_gray 0; FSM IDLE.
- Reset mid-frame: next edge all outputs at reset values, pipeline flushed, no frame_done.
- IMG_H_DISP=1 / IMG_V_DISP=1 legal: single-cycle ACTIVE; V=1 goes ACTIVE->TAIL directly.

## Structure
- Shared package img_stream_pkg: state enum (IDLE..TAIL), clog2-based width helpers, default timing constants shared with the sink/checker blocks.
- One sub-module: img_sync_delay (parameterised N-stage register for vsync/href alignment, synchronous reset).
- Counters: col (clog2 IMG_H_DISP), row (clog2 IMG_V_DISP), phase counter for GAP/LEAD/HBLK/TAIL sized to the largest of those parameters.

## Test plan
Use H=4, V=3, H_BLANK=2, V_LEAD=5, V_TAIL=1, FRAME_GAP=5, memory mem[i]=i+0x10.
- Single frame: start pulse, continuous=0 -> out_vsync high 27-5=22 cycles, 3 bursts of 4 href with 2-cycle gaps, out_gray 10..1B in order, one frame_done, busy low after.
- Latency: first rd_en at cycle t -> out_href=1, out_gray=0x10 at t+2; out_gray=0 in all href-low cycles.
- Continuous: continuous=1, one start -> back-to-back frames, period exactly 27 cycles, rd_addr restarts at 0, frame_done each frame; drop continuous in frame 2 -> frame 2 completes, IDLE.
- start during busy (mid-ACTIVE of row 1) -> no restart, output identical to single-frame case.
- Reset mid-frame (row 1, col 2) -> next edge all outputs 0, no frame_done; new start yields full correct frame from address 0.
- Degenerate H=1, V=1 -> one href pulse, out_gray=0x10, vsync high V_LEAD+1+V_TAIL=7 cycles.
